// File: rtl/vx_onehot_stream_mux.sv
// rtl/vx_onehot_stream_mux.sv - round-robin one-hot stream mux with optional output register and packet lock
module vx_onehot_stream_mux #(
  parameter int NUM_INPUTS  = 4,
  parameter int DATAW       = 32,
  parameter int OUT_BUF     = 1,
  parameter int LOCK_ENABLE = 0,
  parameter int SELW        = NUM_INPUTS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       valid_in,
  input  logic [NUM_INPUTS*DATAW-1:0] data_in,
  input  logic [NUM_INPUTS-1:0]       last_in,
  output logic [NUM_INPUTS-1:0]       ready_in,
  output logic                        valid_out,
  output logic [DATAW-1:0]            data_out,
  output logic [SELW-1:0]             sel_out,
  input  logic                        ready_out
);

  localparam int PTRW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SELW-1:0] lock_sel_q, lock_sel_d;
  logic [SELW-1:0] hi_mask, hi_req, rr_req, rr_grant, grant;
  logic [DATAW-1:0] mux_data;
  logic            stage_ready, xfer, grant_last;

  // Requests at or above rr_ptr win first; otherwise wrap to the lowest request.
  always_comb begin
    hi_mask  = {SELW{1'b1}} << rr_ptr_q;
    hi_req   = valid_in & hi_mask;
    rr_req   = (|hi_req) ? hi_req : valid_in;
    rr_grant = rr_req & (~rr_req + SELW'(1));
    grant    = (state_q == ST_LOCKED) ? (lock_sel_q & valid_in) : rr_grant;
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      mux_data = mux_data | (data_in[i*DATAW +: DATAW] & {DATAW{grant[i]}});
    end
  end

  assign ready_in   = grant & {SELW{stage_ready}};
  assign xfer       = |ready_in;
  assign grant_last = |(grant & last_in);

  // While locked every transfer comes from lock_sel, so advancing past it keeps rr_ptr fixed.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    rr_ptr_d   = rr_ptr_q;
    if (xfer) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (grant[i]) rr_ptr_d = (i == NUM_INPUTS - 1) ? '0 : PTRW'(i + 1);
      end
      case (state_q)
        ST_IDLE: begin
          if (LOCK_ENABLE != 0 && !grant_last) begin
            state_d    = ST_LOCKED;
            lock_sel_d = grant;
          end
        end
        ST_LOCKED: begin
          if (grant_last) begin
            state_d    = ST_IDLE;
            lock_sel_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  if (OUT_BUF != 0) begin : g_buf
    logic             out_valid_q;
    logic [DATAW-1:0] out_data_q;
    logic [SELW-1:0]  out_sel_q;

    // Drain and refill in the same cycle keeps full throughput.
    assign stage_ready = !out_valid_q || ready_out;

    always_ff @(posedge clk) begin
      if (reset) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_sel_q   <= '0;
      end else if (stage_ready) begin
        out_valid_q <= |grant;
        out_data_q  <= mux_data;
        out_sel_q   <= grant;
      end
    end

    assign valid_out = out_valid_q;
    assign data_out  = out_data_q;
    assign sel_out   = out_sel_q;
  end else begin : g_comb
    assign stage_ready = ready_out;
    assign valid_out   = |grant;
    assign data_out    = mux_data;
    assign sel_out     = grant;
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(ready_in));
  a_sel_onehot:   assert property (@(posedge clk) disable iff (reset) valid_out |-> $onehot(sel_out));

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_stable
    a_data_stable: assert property (@(posedge clk) disable iff (reset)
      (valid_in[gi] && !ready_in[gi]) |=> $stable(data_in[gi*DATAW +: DATAW]));
  end

endmodule
